cq_axis_req_decoder: RTL and testbench

CQ_AXIS_REQ_DECODER -- requirements
Module: cq_axis_req_decoder

---
 rtl/cq_pkg.sv | 54 +++++
 rtl/cq_desc_parse.sv | 26 ++
 rtl/cq_axis_req_decoder.sv | 165 ++++++++++++++++
 tb/tb_cq_axis_req_decoder.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cq_pkg.sv
// Shared definitions for the CQ request decoder: request type codes, descriptor
// and tuser field positions, the FSM state enum and the decoded field bundle.
package cq_pkg;

    localparam logic [3:0] MEM_RD = 4'd0;
    localparam logic [3:0] MEM_WR = 4'd1;

    localparam int TUSER_WIDTH = 85;

    // Descriptor (second beat) field positions within tdata
    localparam int DESC_DW_LSB   = 0;
    localparam int DESC_DW_MSB   = 10;
    localparam int DESC_TYPE_LSB = 11;
    localparam int DESC_TYPE_MSB = 14;
    localparam int DESC_RID_LSB  = 16;
    localparam int DESC_RID_MSB  = 31;
    localparam int DESC_TAG_LSB  = 32;
    localparam int DESC_TAG_MSB  = 39;
    localparam int DESC_BAR_LSB  = 48;
    localparam int DESC_BAR_MSB  = 50;

    // tuser field positions
    localparam int TUSER_FBE_LSB     = 0;
    localparam int TUSER_FBE_MSB     = 3;
    localparam int TUSER_LBE_LSB     = 4;
    localparam int TUSER_LBE_MSB     = 7;
    localparam int TUSER_BYTE_EN_LSB = 8;
    localparam int TUSER_BYTE_EN_MSB = 39;
    localparam int TUSER_SOP         = 40;

    typedef enum logic [2:0] {
        ADDR  = 3'd0,
        DESC  = 3'd1,
        DATA  = 3'd2,
        DRAIN = 3'd3,
        OUT   = 3'd4
    } cq_state_e;

    typedef struct packed {
        logic [63:0] addr;
        logic [3:0]  first_be;
        logic [10:0] dword_count;
        logic [3:0]  req_type;
        logic [15:0] requester_id;
        logic [7:0]  tag;
        logic [2:0]  bar_id;
    } cq_fields_t;

    // Only single-DWORD memory reads and writes are decodable.
    function automatic logic fmt_ok(input cq_fields_t f);
        return ((f.req_type == MEM_RD) || (f.req_type == MEM_WR)) && (f.dword_count == 11'd1);
    endfunction

endpackage

// File: rtl/cq_desc_parse.sv
// Combinational extractor: slices address, descriptor and first_be fields out of
// the current CQ beat. Which beat the fields belong to is decided by the caller.
module cq_desc_parse
    import cq_pkg::*;
(
    input  logic [63:0]            tdata,
    input  logic [TUSER_WIDTH-1:0] tuser,
    output cq_fields_t             fields
);

    always_comb begin
        fields              = '0;
        fields.addr         = {tdata[63:2], 2'b00};
        fields.first_be     = tuser[TUSER_FBE_MSB:TUSER_FBE_LSB];
        fields.dword_count  = tdata[DESC_DW_MSB:DESC_DW_LSB];
        fields.req_type     = tdata[DESC_TYPE_MSB:DESC_TYPE_LSB];
        fields.requester_id = tdata[DESC_RID_MSB:DESC_RID_LSB];
        fields.tag          = tdata[DESC_TAG_MSB:DESC_TAG_LSB];
        fields.bar_id       = tdata[DESC_BAR_MSB:DESC_BAR_LSB];
    end

    // last_be, byte_en, sop and the upper tuser bits carry nothing this decoder needs
    logic unused_bits;
    assign unused_bits = ^{tdata[1:0], tuser[TUSER_WIDTH-1:TUSER_FBE_MSB+1]};

endmodule

// File: rtl/cq_axis_req_decoder.sv
// Decodes single-DWORD memory read/write TLPs from a 64-bit CQ AXI-Stream into a
// flat request with a valid/ready handshake; malformed TLPs are dropped and counted.
module cq_axis_req_decoder
    import cq_pkg::*;
#(
    parameter int C_DATA_WIDTH = 64,
    parameter int KEEP_WIDTH   = C_DATA_WIDTH / 32
)(
    input  logic                    user_clk,
    input  logic                    user_reset,
    input  logic [C_DATA_WIDTH-1:0] s_axis_cq_tdata,
    input  logic [TUSER_WIDTH-1:0]  s_axis_cq_tuser,
    input  logic                    s_axis_cq_tlast,
    input  logic [KEEP_WIDTH-1:0]   s_axis_cq_tkeep,
    input  logic                    s_axis_cq_tvalid,
    output logic [21:0]             s_axis_cq_tready,
    output logic                    req_valid,
    input  logic                    req_ready,
    output logic                    req_wr,
    output logic [63:0]             req_addr,
    output logic [31:0]             req_wdata,
    output logic [3:0]              req_be,
    output logic [7:0]              req_tag,
    output logic [15:0]             req_requester_id,
    output logic [2:0]              req_bar_id,
    output logic                    err_pulse,
    output logic [15:0]             err_count,
    output cq_state_e               fsm_state
);

    // Stream handshake: a beat transfers on a rising edge where tvalid and tready
    // are both 1. Request handshake: the request completes on a rising edge where
    // req_valid and req_ready are both 1; req_valid and all req_* fields hold until then.

    cq_state_e  state, state_next;
    cq_fields_t fields;
    logic       tready;
    logic       beat;
    logic       drop;
    logic       cap_addr;
    logic       cap_desc;
    logic       cap_data;
    logic       rd_ok;

    cq_desc_parse u_desc_parse (
        .tdata  (s_axis_cq_tdata),
        .tuser  (s_axis_cq_tuser),
        .fields (fields)
    );

    assign tready           = !user_reset && (state != OUT);
    assign s_axis_cq_tready = {22{tready}};
    assign beat             = s_axis_cq_tvalid && tready;
    assign req_valid        = (state == OUT);
    assign fsm_state        = state;

    always_comb begin
        state_next = state;
        drop       = 1'b0;
        cap_addr   = 1'b0;
        cap_desc   = 1'b0;
        cap_data   = 1'b0;
        rd_ok      = 1'b0;
        case (state)
            ADDR: begin
                if (beat) begin
                    if (s_axis_cq_tlast) begin
                        drop = 1'b1;
                    end else begin
                        cap_addr   = 1'b1;
                        state_next = DESC;
                    end
                end
            end
            DESC: begin
                if (beat) begin
                    cap_desc = 1'b1;
                    if (!fmt_ok(fields)) begin
                        drop       = 1'b1;
                        state_next = s_axis_cq_tlast ? ADDR : DRAIN;
                    end else if (fields.req_type == MEM_RD) begin
                        // A read carries no payload, so the descriptor must end the TLP
                        if (s_axis_cq_tlast) begin
                            rd_ok      = 1'b1;
                            state_next = OUT;
                        end else begin
                            drop       = 1'b1;
                            state_next = DRAIN;
                        end
                    end else begin
                        if (s_axis_cq_tlast) begin
                            drop       = 1'b1;
                            state_next = ADDR;
                        end else begin
                            state_next = DATA;
                        end
                    end
                end
            end
            DATA: begin
                if (beat) begin
                    cap_data = 1'b1;
                    if (s_axis_cq_tlast) begin
                        state_next = OUT;
                    end else begin
                        drop       = 1'b1;
                        state_next = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (beat && s_axis_cq_tlast) begin
                    state_next = ADDR;
                end
            end
            OUT: begin
                if (req_ready) begin
                    state_next = ADDR;
                end
            end
            default: state_next = ADDR;
        endcase
    end

    always_ff @(posedge user_clk) begin
        if (user_reset) begin
            state            <= ADDR;
            req_wr           <= 1'b0;
            req_addr         <= '0;
            req_wdata        <= '0;
            req_be           <= '0;
            req_tag          <= '0;
            req_requester_id <= '0;
            req_bar_id       <= '0;
            err_pulse        <= 1'b0;
            err_count        <= '0;
        end else begin
            state     <= state_next;
            err_pulse <= drop;
            if (drop && (err_count != 16'hFFFF)) begin
                err_count <= err_count + 16'd1;
            end
            if (cap_addr) begin
                req_addr <= fields.addr;
                req_be   <= fields.first_be;
            end
            if (cap_desc) begin
                req_wr           <= (fields.req_type == MEM_WR);
                req_tag          <= fields.tag;
                req_requester_id <= fields.requester_id;
                req_bar_id       <= fields.bar_id;
            end
            if (rd_ok) begin
                req_wdata <= '0;
            end
            if (cap_data) begin
                req_wdata <= s_axis_cq_tdata[31:0];
            end
        end
    end

    logic unused_keep;
    assign unused_keep = ^s_axis_cq_tkeep;

endmodule

// File: tb/tb_cq_axis_req_decoder.sv
// Randomized bench for cq_axis_req_decoder: a TLP-level model predicts requests
// and drop counts; one negedge process compares DUT outputs against it.
module tb_cq_axis_req_decoder;
    import cq_pkg::*;

    logic        user_clk = 1'b0;
    logic        user_reset = 1'b1;
    logic [63:0] tdata = '0;
    logic [84:0] tuser = '0;
    logic        tlast = 1'b0;
    logic [1:0]  tkeep = '0;
    logic        tvalid = 1'b0;
    logic [21:0] tready;
    logic        req_valid;
    logic        req_ready = 1'b0;
    logic        req_wr;
    logic [63:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic [7:0]  req_tag;
    logic [15:0] req_requester_id;
    logic [2:0]  req_bar_id;
    logic        err_pulse;
    logic [15:0] err_count;
    cq_state_e   fsm_state;

    always #5 user_clk = ~user_clk;

    cq_axis_req_decoder dut (
        .user_clk         (user_clk),
        .user_reset       (user_reset),
        .s_axis_cq_tdata  (tdata),
        .s_axis_cq_tuser  (tuser),
        .s_axis_cq_tlast  (tlast),
        .s_axis_cq_tkeep  (tkeep),
        .s_axis_cq_tvalid (tvalid),
        .s_axis_cq_tready (tready),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_wr           (req_wr),
        .req_addr         (req_addr),
        .req_wdata        (req_wdata),
        .req_be           (req_be),
        .req_tag          (req_tag),
        .req_requester_id (req_requester_id),
        .req_bar_id       (req_bar_id),
        .err_pulse        (err_pulse),
        .err_count        (err_count),
        .fsm_state        (fsm_state)
    );

    // Expected request: {wr, addr, wdata, be, tag, requester_id, bar_id}
    logic [127:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    int pulses = 0;
    int n_bad = 0;
    int n_done = 0;
    bit hold_low = 1'b1;
    int ready_pct = 100;
    bit gaps = 1'b0;

    function automatic logic [15:0] sat16(input int n);
        return (n > 65535) ? 16'hFFFF : n[15:0];
    endfunction

    function automatic logic [127:0] act_vec();
        return {req_wr, req_addr, req_wdata, req_be, req_tag, req_requester_id, req_bar_id};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // ---------------- compare process ----------------
    always @(negedge user_clk) begin
        if (user_reset) begin
            pulses = 0;
        end else begin
            if (err_pulse) pulses++;
            check("err_count_track", err_count, sat16(pulses));
            check("tready_rule", tready, req_valid ? 22'h0 : 22'h3FFFFF);
            if (req_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_request actual=%0h required=none", act_vec());
                end else begin
                    check("req_fields", act_vec(), exp_q[0]);
                    if (req_ready) begin
                        void'(exp_q.pop_front());
                        n_done++;
                    end
                end
            end
        end
    end

    always @(posedge user_clk) begin
        #1;
        req_ready = hold_low ? 1'b0 : ($urandom_range(0, 99) < ready_pct);
    end

    // ---------------- driver tasks ----------------
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge user_clk);
            #1;
        end
    endtask

    task automatic send_beat(input logic [63:0] d, input logic [84:0] u, input logic l);
        int budget;
        int g;
        g = 0;
        if (gaps) begin
            while ($urandom_range(0, 1) == 1 && g < 8) begin
                tvalid = 1'b0;
                idle(1);
                g++;
            end
        end
        tvalid = 1'b1;
        tdata  = d;
        tuser  = u;
        tlast  = l;
        tkeep  = 2'($urandom_range(0, 3));
        budget = 0;
        while (budget >= 0) begin
            @(negedge user_clk);
            if (tready[0]) break;
            budget++;
            if (budget > 200) begin
                checks++;
                errors++;
                $display("FAIL beat_accept_timeout actual=tready_low required=accept");
                break;
            end
        end
        @(posedge user_clk);
        #1;
        tvalid = 1'b0;
        tlast  = 1'b0;
    endtask

    task automatic send_tlp(input logic [3:0] typ, input logic [10:0] dw, input int nbeats,
                            input logic [63:0] addr, input logic [3:0] fbe, input logic [7:0] tag,
                            input logic [15:0] rid, input logic [2:0] bar, input logic [63:0] data);
        logic [63:0] desc;
        logic [63:0] d;
        logic [84:0] u;
        logic        ok;
        desc        = {$urandom, $urandom};
        desc[10:0]  = dw;
        desc[14:11] = typ;
        desc[31:16] = rid;
        desc[39:32] = tag;
        desc[50:48] = bar;
        ok = (dw == 11'd1) && (((typ == MEM_RD) && (nbeats == 2)) || ((typ == MEM_WR) && (nbeats == 3)));
        for (int b = 0; b < nbeats; b++) begin
            u = {21'($urandom), $urandom, $urandom};
            if (b == 0) begin
                u[3:0] = fbe;
                u[40]  = 1'b1;
                d      = addr;
            end else begin
                u[40] = 1'b0;
                d     = (b == 1) ? desc : ((b == 2) ? data : {$urandom, $urandom});
            end
            send_beat(d, u, b == nbeats - 1);
        end
        if (ok) begin
            exp_q.push_back({typ == MEM_WR, addr[63:2], 2'b00,
                             (typ == MEM_WR) ? data[31:0] : 32'h0, fbe, tag, rid, bar});
        end else begin
            n_bad++;
        end
    endtask

    task automatic send_random(input logic [3:0] typ, input logic [10:0] dw, input int nbeats);
        send_tlp(typ, dw, nbeats, {$urandom, $urandom}, 4'($urandom_range(0, 15)),
                 8'($urandom), 16'($urandom), 3'($urandom_range(0, 7)), {$urandom, $urandom});
    endtask

    task automatic wait_valid();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge user_clk);
            if (req_valid) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL wait_valid_timeout actual=0 required=1");
        end
    endtask

    task automatic wait_drain();
        int i;
        i = 0;
        while ((exp_q.size() != 0 || req_valid) && i < 3000) begin
            @(negedge user_clk);
            i++;
        end
        if (i >= 3000) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout actual=%0d_pending required=0", exp_q.size());
        end
        @(posedge user_clk);
        #1;
    endtask

    task automatic do_reset();
        user_reset = 1'b1;
        tvalid     = 1'b0;
        exp_q.delete();
        n_bad = 0;
        @(posedge user_clk);
        @(negedge user_clk);
        check("rst_tready", tready, 22'h0);
        check("rst_req_valid", req_valid, 1'b0);
        check("rst_fields", act_vec(), 128'h0);
        check("rst_err_pulse", err_pulse, 1'b0);
        check("rst_err_count", err_count, 16'h0);
        @(posedge user_clk);
        #1;
        user_reset = 1'b0;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int d0;
        logic [3:0]  t;
        logic [10:0] dw;
        #1;
        do_reset();
        @(negedge user_clk);
        check("post_rst_state", fsm_state, ADDR);
        check("post_rst_tready", tready, 22'h3FFFFF);
        @(posedge user_clk);
        #1;

        // Directed single-DWORD write
        hold_low  = 1'b0;
        ready_pct = 100;
        send_tlp(MEM_WR, 11'd1, 3, 64'h1000, 4'hF, 8'h05, 16'h10EE, 3'd0, 64'h0000_0000_AA55_AA55);
        wait_valid();
        check("wr_wr", req_wr, 1'b1);
        check("wr_addr", req_addr, 64'h1000);
        check("wr_wdata", req_wdata, 32'hAA55AA55);
        check("wr_be", req_be, 4'hF);
        check("wr_tag", req_tag, 8'h05);
        check("wr_rid", req_requester_id, 16'h10EE);
        wait_drain();

        // Read with req_ready held low for 5 cycles
        hold_low = 1'b1;
        send_tlp(MEM_RD, 11'd1, 2, 64'h2008, 4'h3, 8'h11, 16'h0102, 3'd2, 64'hDEAD_BEEF_1234_5678);
        wait_valid();
        for (int i = 0; i < 5; i++) begin
            check("rd_hold_valid", req_valid, 1'b1);
            check("rd_hold_addr", req_addr, 64'h2008);
            check("rd_hold_wdata", req_wdata, 32'h0);
            check("rd_hold_tready", tready, 22'h0);
            @(negedge user_clk);
        end
        hold_low = 1'b0;
        wait_drain();
        check("rd_done_valid", req_valid, 1'b0);

        // Write with dword_count 2 is dropped, next TLP decodes
        send_random(MEM_WR, 11'd2, 3);
        idle(3);
        check("bad_dw_err_count", err_count, 16'd1);
        check("bad_dw_pulses", pulses, 1);
        check("bad_dw_no_req", req_valid, 1'b0);
        send_random(MEM_WR, 11'd1, 3);
        wait_drain();

        // 100 valid mixed reads/writes with random gaps and backpressure
        gaps      = 1'b1;
        ready_pct = 60;
        d0        = n_done;
        for (int i = 0; i < 100; i++) begin
            if ($urandom_range(0, 1) == 1) send_random(MEM_WR, 11'd1, 3);
            else send_random(MEM_RD, 11'd1, 2);
        end
        wait_drain();
        check("mixed_req_count", n_done - d0, 100);
        check("mixed_err_count", err_count, 16'd1);

        // Random mix including malformed TLPs
        for (int i = 0; i < 60; i++) begin
            t  = 4'($urandom_range(0, 3));
            dw = ($urandom_range(0, 3) == 0) ? 11'($urandom_range(0, 3)) : 11'd1;
            send_random(t, dw, $urandom_range(1, 4));
        end
        wait_drain();
        idle(3);
        check("mix_err_count", err_count, sat16(n_bad));

        // Reset while in DATA
        gaps = 1'b0;
        send_beat(64'h3000, 85'h1_0000_0000_0F, 1'b0);
        send_beat(64'h0000_0000_0000_0801, 85'h0, 1'b0);
        @(negedge user_clk);
        check("mid_tlp_state", fsm_state, DATA);
        @(posedge user_clk);
        #1;
        do_reset();
        send_random(MEM_WR, 11'd1, 3);
        wait_drain();
        idle(2);
        check("after_rst_err_count", err_count, 16'd0);
        check("after_rst_pulses", pulses, 0);

        // Reset while a request is pending
        hold_low = 1'b1;
        send_random(MEM_RD, 11'd1, 2);
        wait_valid();
        @(posedge user_clk);
        #1;
        do_reset();
        hold_low = 1'b0;
        idle(3);
        check("out_rst_valid", req_valid, 1'b0);
        check("out_rst_err_count", err_count, 16'd0);

        // Saturation: 65536 single-beat TLPs dropped at the address beat
        ready_pct = 100;
        for (int i = 0; i < 65536; i++) begin
            send_beat({$urandom, $urandom}, 85'h1_0000_0000_00, 1'b1);
            n_bad++;
        end
        idle(3);
        check("sat_err_count", err_count, 16'hFFFF);
        for (int i = 0; i < 3; i++) send_random(4'd7, 11'd1, 2);
        idle(3);
        check("sat_hold_err_count", err_count, 16'hFFFF);
        send_random(MEM_WR, 11'd1, 3);
        wait_drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        errors++;
        $display("FAIL watchdog actual=running required=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
